// File: rtl/cordic_ctrl_pkg.sv
// Shared types for the cosine scheduler: tag-pipe slot, response FIFO entry and FSM states.
// Tag and entry ids are sized for the largest supported requester count (8).
package cordic_ctrl_pkg;

    localparam int DEFAULT_COS_LATENCY = 4;
    localparam int TAG_ID_W            = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    typedef struct packed {
        logic [TAG_ID_W-1:0] id;
        logic [31:0]         result;
    } rsp_entry_t;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } sched_state_e;

endpackage

// File: rtl/cosine_rsp_fifo.sv
// Synchronous response FIFO of rsp_entry_t with occupancy count; the head entry is
// presented combinationally and a push is never visible on the output in the same cycle.
module cosine_rsp_fifo
    import cordic_ctrl_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  rsp_entry_t    push_data_i,
    input  logic          pop_i,
    output rsp_entry_t    pop_data_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    rsp_entry_t    mem_q [DEPTH];
    logic          full, do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        // NOTE: every signal written here is given a default first, so no path infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; pointers and count decide validity, so stale words are never seen.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/cosine_scheduler.sv
// Round-robin front end sharing one pipelined cosine unit between NREQ requesters;
// a tag pipe follows each sample and a credit-protected FIFO returns results in issue order.
module cosine_scheduler
    import cordic_ctrl_pkg::*;
#(
    parameter  int NREQ        = 4,
    parameter  int COS_LATENCY = DEFAULT_COS_LATENCY,
    parameter  int FIFO_DEPTH  = 8,
    localparam int IDW         = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_angle,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_result,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy,
    output logic [31:0]          cos_angle,
    output logic                 cos_clk_en,
    output logic                 cos_reset,
    input  logic [31:0]          cos_result
);

    localparam int NSLOT = COS_LATENCY + 1;
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    tag_t         tag_q [NSLOT];
    logic [31:0]  cos_angle_q;
    logic [IDW-1:0] rr_ptr_q;
    sched_state_e state_q, state_d;

    logic [CW-1:0]  inflight, fifo_count;
    logic [CW:0]    credit_used;
    logic           credit_ok, gnt_found, handshake, fifo_empty, rsp_pop;
    logic [IDW-1:0] gnt_id;
    int             cand;
    rsp_entry_t     push_entry, rsp_head;

    always_comb begin
        inflight   = '0;
        cos_clk_en = 1'b0;
        for (int k = 0; k < NSLOT; k++) begin
            inflight   = inflight + CW'(tag_q[k].valid);
            cos_clk_en = cos_clk_en | tag_q[k].valid;
        end
    end

    // Credits count everything that will eventually occupy a FIFO entry; pops this cycle do not count.
    assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
    assign credit_ok   = (credit_used < (CW + 1)'(FIFO_DEPTH));

    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = 0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = (int'(rr_ptr_q) + off) % NREQ;
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = IDW'(cand);
            end
        end
    end

    assign handshake = gnt_found && credit_ok && !reset;

    always_comb begin
        req_ready = '0;
        if (handshake) req_ready[gnt_id] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NSLOT; k++) tag_q[k] <= '0;
            cos_angle_q <= '0;
            rr_ptr_q    <= IDW'(NREQ - 1);
        end else begin
            tag_q[0] <= handshake ? '{valid: 1'b1, id: TAG_ID_W'(gnt_id)} : '0;
            for (int k = 1; k < NSLOT; k++) tag_q[k] <= tag_q[k-1];
            if (handshake) begin
                cos_angle_q <= req_angle[32*gnt_id +: 32];
                rr_ptr_q    <= gnt_id;
            end
        end
    end

    assign cos_angle = cos_angle_q;
    assign cos_reset = reset;

    assign push_entry = '{id: tag_q[NSLOT-1].id, result: cos_result};

    cosine_rsp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (tag_q[NSLOT-1].valid),
        .push_data_i (push_entry),
        .pop_i       (rsp_pop),
        .pop_data_o  (rsp_head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign rsp_valid  = !fifo_empty;
    assign rsp_pop    = rsp_valid && rsp_ready;
    assign rsp_result = fifo_empty ? '0 : rsp_head.result;
    assign rsp_id     = fifo_empty ? '0 : IDW'(rsp_head.id);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (handshake) state_d = ST_ACTIVE;
            ST_ACTIVE: if (inflight == '0 && fifo_empty && !handshake) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    assign busy = (state_q == ST_ACTIVE) || !fifo_empty;

endmodule

// File: tb/tb_cosine_scheduler.sv
// Directed bench for cosine_scheduler with a behavioural 4-stage cosine unit (lookup table)
// that clears its stages whenever clk_en is low; expected responses are queued from the vectors.
module tb_cosine_scheduler;

    localparam int NREQ = 4;

    localparam logic [31:0] ANG_ZERO = 32'h0000_0000;
    localparam logic [31:0] ANG_PI3  = 32'h3F86_0A92;
    localparam logic [31:0] ANG_PI4  = 32'h3F49_0FDB;
    localparam logic [31:0] ANG_PI   = 32'h4049_0FDB;
    localparam logic [31:0] COS_ZERO = 32'h3F80_0000;
    localparam logic [31:0] COS_PI3  = 32'h3F00_0000;
    localparam logic [31:0] COS_PI4  = 32'h3F35_04F3;
    localparam logic [31:0] COS_PI   = 32'hBF80_0000;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [32*NREQ-1:0] req_angle;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid, rsp_ready;
    logic [31:0]       rsp_result;
    logic [1:0]        rsp_id;
    logic              busy;
    logic [31:0]       cos_angle;
    logic              cos_clk_en, cos_reset;
    logic [31:0]       cos_result;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] res;
    } exp_t;

    exp_t exp_q[$];
    exp_t head;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] rr_ang [NREQ] = '{ANG_ZERO, ANG_PI3, ANG_PI4, ANG_PI};
    logic [31:0] rr_cos [NREQ] = '{COS_ZERO, COS_PI3, COS_PI4, COS_PI};

    always #5 clk = ~clk;

    cosine_scheduler #(
        .NREQ        (NREQ),
        .COS_LATENCY (4),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_angle  (req_angle),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_id     (rsp_id),
        .busy       (busy),
        .cos_angle  (cos_angle),
        .cos_clk_en (cos_clk_en),
        .cos_reset  (cos_reset),
        .cos_result (cos_result)
    );

    function automatic logic [31:0] cos_lut(input logic [31:0] a);
        case (a)
            ANG_ZERO: return COS_ZERO;
            ANG_PI3:  return COS_PI3;
            ANG_PI4:  return COS_PI4;
            ANG_PI:   return COS_PI;
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Input register plus three stages; clk_en low clears the pipeline.
    logic [31:0] cs0, cs1, cs2, cs3;
    always @(posedge clk or posedge cos_reset) begin
        if (cos_reset) begin
            cs0 <= '0; cs1 <= '0; cs2 <= '0; cs3 <= '0;
        end else if (cos_clk_en) begin
            cs0 <= cos_angle;
            cs1 <= cos_lut(cs0);
            cs2 <= cs1;
            cs3 <= cs2;
        end else begin
            cs0 <= '0; cs1 <= '0; cs2 <= '0; cs3 <= '0;
        end
    end
    assign cos_result = cs3;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic check_reset_outputs(input string phase);
        check({phase, "_req_ready"},  req_ready,  0);
        check({phase, "_rsp_valid"},  rsp_valid,  0);
        check({phase, "_rsp_result"}, rsp_result, 0);
        check({phase, "_rsp_id"},     rsp_id,     0);
        check({phase, "_busy"},       busy,       0);
        check({phase, "_cos_angle"},  cos_angle,  0);
        check({phase, "_cos_clk_en"}, cos_clk_en, 0);
        check({phase, "_cos_reset"},  cos_reset,  1);
    endtask

    // Every accepted response is compared against the head of the expected queue.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 0);
            end else begin
                head = exp_q.pop_front();
                check("rsp_id", rsp_id, head.id);
                check("rsp_result", rsp_result, head.res);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0] exp_rdy;

        reset     = 1'b1;
        req_valid = '0;
        req_angle = '0;
        rsp_ready = 1'b1;
        step();
        step();
        #1;
        check_reset_outputs("rst");
        reset = 1'b0;
        step();
        step();

        // Idle: nothing issued, datapath gated off.
        #1;
        check("idle_clk_en", cos_clk_en, 0);
        check("idle_busy",   busy,       0);
        check("idle_cos_reset", cos_reset, 0);
        step();

        // Single request from requester 0: push 5 edges after the handshake.
        req_valid       = 4'b0001;
        req_angle[31:0] = ANG_ZERO;
        #1;
        check("single_ready", req_ready, 4'b0001);
        exp_q.push_back('{id: 2'd0, res: COS_ZERO});
        step();
        req_valid = '0;
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("single_clk_en_%0d", k),    cos_clk_en, (k < 5) ? 1 : 0);
            check($sformatf("single_rsp_valid_%0d", k), rsp_valid,  (k == 5) ? 1 : 0);
            check($sformatf("single_busy_%0d", k),      busy,       (k <= 6) ? 1 : 0);
            step();
        end
        check("single_drained", exp_q.size(), 0);

        // Round robin with all requesters valid; reset puts requester 0 first.
        pulse_reset();
        req_valid = 4'b1111;
        for (int r = 0; r < NREQ; r++) req_angle[32*r +: 32] = rr_ang[r];
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_rdy = 4'b0001 << (i % NREQ);
            check($sformatf("rr_grant_%0d", i), req_ready, exp_rdy);
            exp_q.push_back('{id: 2'(i % NREQ), res: rr_cos[i % NREQ]});
            step();
        end
        req_valid = '0;
        for (int i = 0; i < 10; i++) step();
        #1;
        check("rr_drained", exp_q.size(), 0);
        check("rr_busy",    busy,         0);
        step();

        // Backpressure: exactly FIFO_DEPTH issues, then credits run out.
        rsp_ready        = 1'b0;
        req_valid        = 4'b0010;
        req_angle[63:32] = ANG_PI4;
        for (int k = 0; k < 12; k++) begin
            #1;
            exp_rdy = (k < 8) ? 4'b0010 : 4'b0000;
            check($sformatf("bp_grant_%0d", k), req_ready, exp_rdy);
            if (k < 8) exp_q.push_back('{id: 2'd1, res: COS_PI4});
            step();
        end
        req_valid = '0;
        for (int k = 0; k < 3; k++) step();
        #1;
        check("bp_full_valid", rsp_valid, 1);
        check("bp_full_busy",  busy,      1);

        // Release backpressure; the first cycle still has no credit.
        rsp_ready        = 1'b1;
        req_valid        = 4'b0010;
        req_angle[63:32] = ANG_PI3;
        #1;
        check("bp_no_credit", req_ready, 4'b0000);
        step();
        for (int j = 0; j < 3; j++) begin
            #1;
            check($sformatf("bp_resume_%0d", j), req_ready, 4'b0010);
            exp_q.push_back('{id: 2'd1, res: COS_PI3});
            step();
        end
        req_valid = '0;
        for (int k = 0; k < 16; k++) step();
        #1;
        check("bp_drained", exp_q.size(), 0);
        check("bp_busy",    busy,         0);
        step();

        // Reset with three samples in flight; nothing may emerge afterwards.
        req_valid        = 4'b0100;
        req_angle[95:64] = ANG_PI;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("mid_grant_%0d", i), req_ready, 4'b0100);
            step();
        end
        reset = 1'b1;
        #1;
        check_reset_outputs("mid");
        step();
        step();
        req_valid = '0;
        reset     = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            check($sformatf("post_rst_valid_%0d", k), rsp_valid,  0);
            check($sformatf("post_rst_clk_en_%0d", k), cos_clk_en, 0);
            step();
        end
        req_valid       = 4'b0001;
        req_angle[31:0] = ANG_PI3;
        #1;
        check("post_rst_grant", req_ready, 4'b0001);
        exp_q.push_back('{id: 2'd0, res: COS_PI3});
        step();
        req_valid = '0;
        for (int k = 0; k < 10; k++) step();
        #1;
        check("post_rst_drained", exp_q.size(), 0);
        check("post_rst_busy",    busy,         0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
